// File: rtl/trail_pkg.sv
// Shared types and pixel helpers for the trail IIR pipeline.
// Pixels are packed {Y, Cr, Cb} with Y in the MSBs.
package trail_pkg;

    localparam int unsigned TRAIL_Y_BITS   = 4;
    localparam int unsigned TRAIL_CR_BITS  = 2;
    localparam int unsigned TRAIL_CB_BITS  = 2;
    localparam int unsigned TRAIL_PIX_BITS = TRAIL_Y_BITS + TRAIL_CR_BITS + TRAIL_CB_BITS;

    typedef enum logic [1:0] {
        PERSIST = 2'd0,
        MAX     = 2'd1,
        FREEZE  = 2'd2,
        CLEAR   = 2'd3
    } trail_mode_t;

    function automatic logic [TRAIL_Y_BITS-1:0] get_y(input logic [TRAIL_PIX_BITS-1:0] pix);
        return pix[TRAIL_PIX_BITS-1 -: TRAIL_Y_BITS];
    endfunction

    function automatic logic [TRAIL_CR_BITS-1:0] get_cr(input logic [TRAIL_PIX_BITS-1:0] pix);
        return pix[TRAIL_CB_BITS +: TRAIL_CR_BITS];
    endfunction

    function automatic logic [TRAIL_CB_BITS-1:0] get_cb(input logic [TRAIL_PIX_BITS-1:0] pix);
        return pix[TRAIL_CB_BITS-1:0];
    endfunction

    function automatic logic [TRAIL_PIX_BITS-1:0] pack_pixel(
        input logic [TRAIL_Y_BITS-1:0]  y,
        input logic [TRAIL_CR_BITS-1:0] cr,
        input logic [TRAIL_CB_BITS-1:0] cb
    );
        return {y, cr, cb};
    endfunction

endpackage

// File: rtl/trail_decay_mul.sv
// Registered luma decay: y_dec = floor(hy * decay / 2^DECAY_BITS), bypassed when inactive.
// Kept separate so the multiply can be retimed or mapped onto a DSP block on its own.
module trail_decay_mul #(
    parameter int unsigned Y_BITS     = 4,
    parameter int unsigned DECAY_BITS = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  en_in,
    input  logic [Y_BITS-1:0]     hy_in,
    input  logic [DECAY_BITS-1:0] decay_in,
    input  logic                  active_in,
    output logic [Y_BITS-1:0]     y_dec_out
);

    localparam int unsigned PROD_BITS = Y_BITS + DECAY_BITS;

    logic [PROD_BITS-1:0] prod;
    logic [Y_BITS-1:0]    y_dec_d;
    logic [Y_BITS-1:0]    y_dec_q;

    assign prod = {{DECAY_BITS{1'b0}}, hy_in} * {{Y_BITS{1'b0}}, decay_in};

    always_comb begin
        y_dec_d = hy_in;
        if (active_in) begin
            y_dec_d = prod[DECAY_BITS +: Y_BITS];
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            y_dec_q <= '0;
        end else if (en_in) begin
            y_dec_q <= y_dec_d;
        end
    end

    assign y_dec_out = y_dec_q;

endmodule

// File: rtl/trail_iir_pipe.sv
// Two-stage valid/ready trail filter: merges a history pixel with a camera pixel using
// frame-latched decay, threshold, merge mode and a frame-periodic decay schedule.
module trail_iir_pipe import trail_pkg::*; #(
    parameter int unsigned Y_BITS           = TRAIL_Y_BITS,
    parameter int unsigned CR_BITS          = TRAIL_CR_BITS,
    parameter int unsigned CB_BITS          = TRAIL_CB_BITS,
    parameter int unsigned COLOR_DEPTH      = Y_BITS + CR_BITS + CB_BITS,
    parameter int unsigned DECAY_BITS       = 8,
    parameter int unsigned PERIOD_BITS      = 4,
    parameter logic [DECAY_BITS-1:0] DEFAULT_DECAY     = 8'hFC,
    parameter logic [Y_BITS-1:0]     DEFAULT_THRESHOLD = 4'd11
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   s_valid_in,
    output logic                   s_ready_out,
    input  logic                   s_frame_start_in,
    input  logic [COLOR_DEPTH-1:0] history_in,
    input  logic [COLOR_DEPTH-1:0] camera_in,
    input  logic [DECAY_BITS-1:0]  decay_in,
    input  logic [Y_BITS-1:0]      threshold_in,
    input  logic [1:0]             mode_in,
    input  logic [PERIOD_BITS-1:0] period_in,
    output logic                   m_valid_out,
    input  logic                   m_ready_in,
    output logic                   m_frame_start_out,
    output logic [COLOR_DEPTH-1:0] update_out
);

    logic en1, en2, accept, load_cfg;

    logic [DECAY_BITS-1:0]  decay_q, cfg_decay;
    logic [Y_BITS-1:0]      thr_q, cfg_thr;
    trail_mode_t            mode_q, cfg_mode;
    logic [PERIOD_BITS-1:0] period_q, cfg_period;
    logic [PERIOD_BITS-1:0] cnt_q, cnt_d;
    logic                   active_q, cfg_active;

    logic                   v1_q, fs1_q;
    logic [COLOR_DEPTH-1:0] hist1_q, cam1_q;
    logic [Y_BITS-1:0]      thr1_q;
    trail_mode_t            mode1_q;
    logic [Y_BITS-1:0]      y_dec1;

    logic                   v2_q, fs2_q;
    logic [COLOR_DEPTH-1:0] update_q;
    logic [COLOR_DEPTH-1:0] decayed, merged;

    assign en2         = !v2_q || m_ready_in;
    assign en1         = !v1_q || en2;
    assign s_ready_out = en1;
    assign accept      = s_valid_in && en1;
    assign load_cfg    = accept && s_frame_start_in;

    // A frame-start beat already runs with the configuration it latches.
    always_comb begin
        cfg_decay  = decay_q;
        cfg_thr    = thr_q;
        cfg_mode   = mode_q;
        cfg_period = period_q;
        cfg_active = active_q;
        if (load_cfg) begin
            cfg_decay  = decay_in;
            cfg_thr    = threshold_in;
            cfg_mode   = trail_mode_t'(mode_in);
            cfg_period = period_in;
            cfg_active = (cnt_q == '0);
        end
    end

    always_comb begin
        cnt_d = cnt_q + PERIOD_BITS'(1);
        if (cfg_period <= PERIOD_BITS'(1) || cnt_q == cfg_period - PERIOD_BITS'(1)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            decay_q  <= DEFAULT_DECAY;
            thr_q    <= DEFAULT_THRESHOLD;
            mode_q   <= PERSIST;
            period_q <= PERIOD_BITS'(1);
            cnt_q    <= '0;
            active_q <= 1'b1;
        end else if (load_cfg) begin
            decay_q  <= cfg_decay;
            thr_q    <= cfg_thr;
            mode_q   <= cfg_mode;
            period_q <= cfg_period;
            cnt_q    <= cnt_d;
            active_q <= cfg_active;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            v1_q    <= 1'b0;
            fs1_q   <= 1'b0;
            hist1_q <= '0;
            cam1_q  <= '0;
            thr1_q  <= '0;
            mode1_q <= PERSIST;
        end else begin
            if (en1) begin
                v1_q <= s_valid_in;
            end
            if (accept) begin
                fs1_q   <= s_frame_start_in;
                hist1_q <= history_in;
                cam1_q  <= camera_in;
                thr1_q  <= cfg_thr;
                mode1_q <= cfg_mode;
            end
        end
    end

    trail_decay_mul #(
        .Y_BITS     (Y_BITS),
        .DECAY_BITS (DECAY_BITS)
    ) u_decay_mul (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .en_in      (accept),
        .hy_in      (get_y(history_in)),
        .decay_in   (cfg_decay),
        .active_in  (cfg_active),
        .y_dec_out  (y_dec1)
    );

    always_comb begin
        decayed = pack_pixel(y_dec1, get_cr(hist1_q), get_cb(hist1_q));
        merged  = cam1_q;
        unique case (mode1_q)
            PERSIST: merged = (get_y(hist1_q) > thr1_q) ? decayed : cam1_q;
            MAX:     merged = (y_dec1 > get_y(cam1_q)) ? decayed : cam1_q;
            FREEZE:  merged = hist1_q;
            CLEAR:   merged = cam1_q;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            v2_q     <= 1'b0;
            fs2_q    <= 1'b0;
            update_q <= '0;
        end else if (en2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                fs2_q    <= fs1_q;
                update_q <= merged;
            end
        end
    end

    assign m_valid_out       = v2_q;
    assign m_frame_start_out = fs2_q;
    assign update_out        = update_q;

endmodule

// File: tb/tb_trail_iir_pipe.sv
// Directed self-checking bench for trail_iir_pipe with hand-computed expected pixels.
module tb_trail_iir_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic       s_fs = 1'b0;
    logic [7:0] history = '0;
    logic [7:0] camera = '0;
    logic [7:0] decay = 8'h00;
    logic [3:0] threshold = 4'd0;
    logic [1:0] mode = 2'd0;
    logic [3:0] period = 4'd1;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic       m_fs;
    logic [7:0] update;

    int compared = 0;
    int mismatched = 0;

    logic [7:0] out_q[$];
    logic       fs_q[$];

    trail_iir_pipe dut (
        .clk_in            (clk),
        .rst_n_in          (rst_n),
        .s_valid_in        (s_valid),
        .s_ready_out       (s_ready),
        .s_frame_start_in  (s_fs),
        .history_in        (history),
        .camera_in         (camera),
        .decay_in          (decay),
        .threshold_in      (threshold),
        .mode_in           (mode),
        .period_in         (period),
        .m_valid_out       (m_valid),
        .m_ready_in        (m_ready),
        .m_frame_start_out (m_fs),
        .update_out        (update)
    );

    always #5 clk = ~clk;

    // Inputs change at posedge+1, so a transfer seen here fires at the next posedge.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            out_q.push_back(update);
            fs_q.push_back(m_fs);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    task automatic set_cfg(input logic [7:0] d, input logic [3:0] t, input logic [1:0] m,
                           input logic [3:0] p);
        decay = d;
        threshold = t;
        mode = m;
        period = p;
    endtask

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic send(input logic fs, input logic [7:0] h, input logic [7:0] c);
        logic acc;
        acc = 1'b0;
        s_valid = 1'b1;
        s_fs = fs;
        history = h;
        camera = c;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_fs = 1'b0;
        if (!acc) begin
            compared++;
            mismatched++;
            $display("FAIL send_timeout: beat h=%h c=%h never accepted, required accept", h, c);
        end
    endtask

    task automatic wait_out(input int n);
        int i;
        i = 0;
        while (out_q.size() < n && i < 100) begin
            @(posedge clk);
            #1;
            i++;
        end
        compared++;
        if (out_q.size() < n) begin
            mismatched++;
            $display("FAIL out_timeout: got %0d outputs, required %0d", out_q.size(), n);
        end
    endtask

    task automatic check_outs(input string name, input logic [7:0] exp[$]);
        for (int i = 0; i < exp.size(); i++) begin
            compared++;
            if (i >= out_q.size() || out_q[i] !== exp[i]) begin
                mismatched++;
                $display("FAIL %s[%0d]: got %h, required %h", name, i,
                         (i < out_q.size()) ? out_q[i] : 8'hxx, exp[i]);
            end
        end
    endtask

    task automatic test_reset();
        #12;
        compared += 3;
        if (m_valid !== 1'b0) begin
            mismatched++; $display("FAIL reset_m_valid: got %b, required 0", m_valid);
        end
        if (update !== 8'h00) begin
            mismatched++; $display("FAIL reset_update: got %h, required 00", update);
        end
        if (m_fs !== 1'b0) begin
            mismatched++; $display("FAIL reset_m_fs: got %b, required 0", m_fs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        compared++;
        if (s_ready !== 1'b1) begin
            mismatched++; $display("FAIL reset_s_ready: got %b, required 1", s_ready);
        end
    endtask

    task automatic test_persist();
        out_q.delete();
        fs_q.delete();
        set_cfg(8'hF0, 4'd11, 2'd0, 4'd1);
        send(1'b1, 8'hF9, 8'h35);
        compared++;
        if (m_valid !== 1'b0) begin
            mismatched++; $display("FAIL persist_latency_early: m_valid %b, required 0", m_valid);
        end
        @(posedge clk);
        #1;
        compared += 3;
        if (m_valid !== 1'b1) begin
            mismatched++; $display("FAIL persist_latency: m_valid %b, required 1", m_valid);
        end
        if (update !== 8'hE9) begin
            mismatched++; $display("FAIL persist_first: got %h, required e9", update);
        end
        if (m_fs !== 1'b1) begin
            mismatched++; $display("FAIL persist_fs: got %b, required 1", m_fs);
        end
        send(1'b0, 8'hB6, 8'h7A);
        send(1'b0, 8'hC6, 8'h7A);
        wait_out(3);
        check_outs("persist", '{8'hE9, 8'h7A, 8'hB6});
        compared++;
        if (fs_q.size() < 2 || fs_q[1] !== 1'b0) begin
            mismatched++; $display("FAIL persist_fs_mid: got %b, required 0",
                                   (fs_q.size() > 1) ? fs_q[1] : 1'bx);
        end
    endtask

    task automatic test_max();
        out_q.delete();
        set_cfg(8'hF0, 4'd11, 2'd1, 4'd1);
        send(1'b1, 8'hF9, 8'hE0);
        send(1'b0, 8'hF9, 8'hD0);
        wait_out(2);
        check_outs("max", '{8'hE0, 8'hE9});
    endtask

    task automatic test_boundary();
        out_q.delete();
        set_cfg(8'h00, 4'd0, 2'd0, 4'd1);
        send(1'b1, 8'hF9, 8'h35);
        set_cfg(8'hFF, 4'd0, 2'd0, 4'd1);
        send(1'b1, 8'hF9, 8'h35);
        send(1'b0, 8'h1B, 8'h35);
        set_cfg(8'hFF, 4'd15, 2'd0, 4'd1);
        send(1'b1, 8'hF9, 8'h35);
        set_cfg(8'hFF, 4'd15, 2'd2, 4'd1);
        send(1'b1, 8'hC6, 8'h35);
        set_cfg(8'hFF, 4'd15, 2'd3, 4'd1);
        send(1'b1, 8'hC6, 8'h35);
        wait_out(6);
        check_outs("boundary", '{8'h09, 8'hE9, 8'h0B, 8'h35, 8'hC6, 8'h35});
    endtask

    task automatic test_period();
        out_q.delete();
        set_cfg(8'h80, 4'd11, 2'd0, 4'd3);
        send(1'b1, 8'hF9, 8'h35);
        decay = 8'h00;
        send(1'b0, 8'hF9, 8'h35);
        decay = 8'h80;
        send(1'b1, 8'hF9, 8'h35);
        send(1'b1, 8'hF9, 8'h35);
        send(1'b1, 8'hF9, 8'h35);
        wait_out(5);
        check_outs("period", '{8'h79, 8'h79, 8'hF9, 8'hF9, 8'h79});
    endtask

    task automatic test_back_to_back();
        out_q.delete();
        set_cfg(8'h80, 4'd11, 2'd3, 4'd1);
        m_ready = 1'b0;
        fork
            begin
                send(1'b1, 8'h11, 8'hA1);
                send(1'b0, 8'h22, 8'hA2);
                set_cfg(8'h80, 4'd11, 2'd2, 4'd1);
                send(1'b1, 8'h33, 8'hFF);
                send(1'b0, 8'h44, 8'hFF);
                send(1'b0, 8'h55, 8'hFF);
                send(1'b0, 8'h66, 8'hFF);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                compared += 3;
                if (s_ready !== 1'b0) begin
                    mismatched++; $display("FAIL bp_s_ready: got %b, required 0", s_ready);
                end
                if (m_valid !== 1'b1) begin
                    mismatched++; $display("FAIL bp_m_valid: got %b, required 1", m_valid);
                end
                if (update !== 8'hA1) begin
                    mismatched++; $display("FAIL bp_head: got %h, required a1", update);
                end
                repeat (3) @(posedge clk);
                #1;
                compared++;
                if (update !== 8'hA1 || m_fs !== 1'b1) begin
                    mismatched++;
                    $display("FAIL bp_hold: got %h/%b, required a1/1", update, m_fs);
                end
                m_ready = 1'b1;
            end
        join
        wait_out(6);
        check_outs("bp", '{8'hA1, 8'hA2, 8'h33, 8'h44, 8'h55, 8'h66});
        repeat (4) @(posedge clk);
        #1;
        compared++;
        if (out_q.size() != 6) begin
            mismatched++; $display("FAIL bp_count: got %0d outputs, required 6", out_q.size());
        end
    endtask

    task automatic test_reset_midburst();
        set_cfg(8'h00, 4'd0, 2'd3, 4'd1);
        send(1'b1, 8'h11, 8'hA1);
        send(1'b0, 8'h22, 8'hA2);
        out_q.delete();
        #2;
        rst_n = 1'b0;
        #1;
        compared += 2;
        if (m_valid !== 1'b0) begin
            mismatched++; $display("FAIL rst_mid_m_valid: got %b, required 0", m_valid);
        end
        if (update !== 8'h00) begin
            mismatched++; $display("FAIL rst_mid_update: got %h, required 00", update);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        compared++;
        if (s_ready !== 1'b1) begin
            mismatched++; $display("FAIL rst_mid_s_ready: got %b, required 1", s_ready);
        end
        send(1'b0, 8'hF9, 8'h35);
        wait_out(1);
        check_outs("rst_mid", '{8'hE9});
        repeat (4) @(posedge clk);
        #1;
        compared++;
        if (out_q.size() != 1) begin
            mismatched++; $display("FAIL rst_mid_count: got %0d outputs, required 1", out_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_persist();
        test_max();
        test_boundary();
        test_period();
        test_back_to_back();
        test_reset_midburst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
